mem_wb_stage_hs: RTL
====================

// Module: mem_wb_stage_hs
// PURPOSE
//  Parametrised MEM->WB pipeline register with a valid/ready handshake, stall, flush and an optional skid entry.
//  Carries {wb_en, rw, data} from the memory stage to register-file write-back.
//  Also drives a forwarding tap to the hazard unit.
//  Replaces the always-enabled MEM/WB register, which has no stall, flush or valid qualification.
// PARAMETERS
//  DATA_W   32  width of write-back data
//  RW_W      5  width of destination register index
//  SKID      1  0: single register, ready combinational; 1: 2-entry skid buffer, o_ready registered
// PORTS
//  i_clk       in   1        clock, rising edge
//  i_rst_n     in   1        asynchronous reset, active low
//  i_valid     in   1        upstream (MEM) payload valid
//  o_ready     out  1        stage can accept payload this cycle
//  i_data      in   DATA_W   write-back data
//  i_Rw        in   RW_W     destination register index
//  i_WB        in   1        register write enable from control
//  i_flush     in   1        synchronous flush: drop all held entries
//  o_valid     out  1        output payload valid
//  i_ready     in   1        downstream (WB) accepts payload
//  o_data      out  DATA_W   held write-back data
//  o_Rw        out  RW_W     held destination index
//  o_WB        out  1        register write strobe = held wb_en & o_valid
//  o_fwd_hit   out  1        o_valid & held wb_en & (o_Rw != 0), for forwarding
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): o_valid=0, o_data=0, o_Rw=0, o_WB=0, o_fwd_hit=0.
//    Skid entry is cleared. o_ready=1 once reset is released.
//  - Transfer in: i_valid & o_ready at a rising edge. Transfer out: o_valid & i_ready at a rising edge.
//  - Latency: 1 cycle from accepted input to o_valid.
//  - Payload bits never change while o_valid=1 & i_ready=0 (stall hold).
//  - SKID=0: o_ready = !o_valid | i_ready. The main register loads on transfer in.
//    o_valid clears when there is a transfer out and no transfer in.
//  - SKID=1, states EMPTY/ONE/TWO, in the shared package:
//    EMPTY: in -> ONE.
//    ONE: in & !out -> TWO (input goes to skid). out & !in -> EMPTY. in & out -> ONE (main reloads).
//    TWO: out -> ONE (main <= skid, skid cleared). o_ready=0 in TWO.
//    o_ready = (state != TWO), registered. Sustains 1 transfer/cycle with i_ready toggling.
//  - Flush: i_flush=1 at an edge forces EMPTY / o_valid=0 next cycle. Payload regs reset to 0.
//    It overrides a simultaneous transfer in, which is dropped; the upstream handshake still completes.
//    A simultaneous transfer out still counts as delivered.
//  - o_WB and o_fwd_hit are combinational from the held regs. o_WB is never 1 while o_valid=0.
//  - Reset asserted mid-operation: all entries are lost immediately, no partial state.
//  - Payload widths are passed through, no arithmetic. i_Rw=0 is legal; o_fwd_hit masks it.
// STRUCTURE
//  - Shared package mips_pipe_pkg: DATA_W=32 and RW_W=5 defaults, SKID state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
//  - Sub-module pipe_skid_buf #(WIDTH, SKID): generic handshake buffer on a packed payload.
//    This stage instantiates it with WIDTH = DATA_W+RW_W+1 and adds the o_WB / o_fwd_hit gating.
// TESTING
//  1 Reset: i_rst_n=0 mid-cycle -> all outputs 0 immediately. After release o_ready=1 and o_valid=0.
//  2 Pass-through: i_ready=1, push data 0xDEADBEEF, Rw=5, WB=1 -> next cycle o_valid=1, o_data=0xDEADBEEF, o_WB=1, o_fwd_hit=1.
//  3 Stall (SKID=1): i_ready=0, push A then B -> TWO, o_ready=0, o_data=A held.
//    Raise i_ready -> A out, then B out, no loss or duplication.
//  4 Throughput (SKID=1): 100 random words, i_ready random 50% -> output sequence equals input order.
//    Zero bubbles whenever i_ready=1 and the buffer is non-empty.
//  5 Flush: in TWO, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_WB=0, o_ready=1. The flushed-cycle input never appears.
//  6 Rw=0 with WB=1 -> o_WB=1, o_fwd_hit=0. Repeat steps 2-5 with SKID=0 and DATA_W=64.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: default payload widths
// and the state encoding used by the two-entry skid buffer.
package mips_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RW_W_DEF   = 5;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready handshake buffer on a packed payload with synchronous flush.
// SKID=0 is a single register with combinational ready; SKID=1 adds a skid entry and registers ready.
module pipe_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int WIDTH = 38,
  parameter bit SKID  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic xfer_in;
  logic xfer_out;

  assign xfer_in  = i_valid & o_ready;
  assign xfer_out = o_valid & i_ready;

  generate
    if (SKID == 1'b0) begin : g_single
      logic             valid_q, valid_d;
      logic [WIDTH-1:0] main_q, main_d;

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (i_flush) begin
          valid_d = 1'b0;
          main_d  = '0;
        end else if (xfer_in) begin
          valid_d = 1'b1;
          main_d  = i_data;
        end else if (xfer_out) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign o_ready = !valid_q | i_ready;
      assign o_valid = valid_q;
      assign o_data  = main_q;
    end else begin : g_skid
      skid_state_e      state_q, state_d;
      logic             ready_q;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
          state_d = SKID_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end else begin
          unique case (state_q)
            SKID_EMPTY: begin
              if (xfer_in) begin
                state_d = SKID_ONE;
                main_d  = i_data;
              end
            end
            SKID_ONE: begin
              if (xfer_in && xfer_out) begin
                main_d = i_data;
              end else if (xfer_in) begin
                state_d = SKID_TWO;
                skid_d  = i_data;
              end else if (xfer_out) begin
                state_d = SKID_EMPTY;
              end
            end
            SKID_TWO: begin
              // ready is low here, so only the drain side can move
              if (xfer_out) begin
                state_d = SKID_ONE;
                main_d  = skid_q;
                skid_d  = '0;
              end
            end
            default: state_d = SKID_EMPTY;
          endcase
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          state_q <= SKID_EMPTY;
          ready_q <= 1'b1;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          ready_q <= (state_d != SKID_TWO);
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      assign o_ready = ready_q;
      assign o_valid = (state_q != SKID_EMPTY);
      assign o_data  = main_q;
    end
  endgenerate

endmodule

// File: rtl/mem_wb_stage_hs.sv
// MEM->WB pipeline register with valid/ready handshake, stall, flush and optional skid entry.
// Carries {wb_en, rw, data} and derives the write strobe and forwarding tap from the held entry.
module mem_wb_stage_hs
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RW_W   = RW_W_DEF,
  parameter bit SKID   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [RW_W-1:0]   i_Rw,
  input  logic              i_WB,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [RW_W-1:0]   o_Rw,
  output logic              o_WB,
  output logic              o_fwd_hit
);

  localparam int PAY_W = DATA_W + RW_W + 1;

  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;
  logic             held_wb;

  assign pay_in = {i_WB, i_Rw, i_data};

  pipe_skid_buf #(
    .WIDTH (PAY_W),
    .SKID  (SKID)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (pay_in),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (pay_out)
  );

  assign {held_wb, o_Rw, o_data} = pay_out;

  // register 0 is hard-wired, so a write to it must never forward
  assign o_WB      = held_wb & o_valid;
  assign o_fwd_hit = o_WB & (o_Rw != '0);

endmodule
